mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the pipeline's instruction-fetch port
//  and its data-memory (MEM stage) port. Sequences one transaction at a time onto the

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// data-memory port. One transaction at a time goes onto the memory with a
// req/ack handshake. Each finished transaction returns data and a one-cycle
// ready pulse to its port. pipe_stall tells the hazard logic to freeze the pipe.
// DM wins simultaneous requests unless fetch has already waited behind
// STARVE_MAX consecutive DM grants.
// Optional feature: define ARB_PERF_CNT_EN to build the two 32-bit performance
// counters. Without it, perf_conflict and perf_if_wait are tied to zero.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              pipe_stall,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_if_wait
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  starve_cnt_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] dm_rdata_reg;
    logic              if_ready_reg;
    logic              dm_ready_reg;

    // A requester still holds its req during its ready cycle. No grant is made
    // in that cycle, so a finished request is never mistaken for a new one.
    logic ready_busy;
    logic fetch_starved;
    logic grant_dm;
    logic grant_if;

    // Arbitration decision, used only while idle.
    always_comb begin
        ready_busy    = if_ready_reg | dm_ready_reg;
        fetch_starved = if_req & (starve_cnt_reg == STARVE_LIMIT);
        grant_dm      = ~ready_busy & dm_req & ~fetch_starved;
        grant_if      = ~ready_busy & ~grant_dm & if_req;
    end

    // Arbiter FSM: grant, hold the command until ack, then return data and pulse ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_rdata_reg   <= '0;
            dm_rdata_reg   <= '0;
            if_ready_reg   <= 1'b0;
            dm_ready_reg   <= 1'b0;
        end else begin
            if_ready_reg <= 1'b0;
            dm_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_dm) begin
                        state_reg     <= GRANT_DM;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= dm_we;
                        mem_addr_reg  <= dm_addr;
                        mem_wdata_reg <= dm_wdata;
                        // Count consecutive DM grants that fetch had to sit through.
                        if (if_req) begin
                            if (starve_cnt_reg != STARVE_LIMIT)
                                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
                        end else begin
                            starve_cnt_reg <= '0;
                        end
                    end else if (grant_if) begin
                        state_reg      <= GRANT_IF;
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= 1'b0;
                        mem_addr_reg   <= if_addr;
                        starve_cnt_reg <= '0;
                    end
                end
                GRANT_IF: begin
                    if (mem_ack) begin
                        state_reg    <= IDLE;
                        mem_req_reg  <= 1'b0;
                        if_rdata_reg <= mem_rdata;
                        if_ready_reg <= 1'b1;
                    end
                end
                GRANT_DM: begin
                    if (mem_ack) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        // Stores leave the load-data register untouched.
                        if (!mem_we_reg)
                            dm_rdata_reg <= mem_rdata;
                        dm_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                    mem_we_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign if_ready  = if_ready_reg;
    assign dm_ready  = dm_ready_reg;

    // A port stalls the pipe from request until its ready pulse.
    assign pipe_stall = (if_req & ~if_ready_reg) | (dm_req & ~dm_ready_reg);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_conflict_reg;
    logic [31:0] perf_if_wait_reg;

    // Performance counters: cycles both ports contend, and cycles fetch waits behind DM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_conflict_reg <= '0;
            perf_if_wait_reg  <= '0;
        end else begin
            if (if_req & dm_req & ~if_ready_reg & ~dm_ready_reg)
                perf_conflict_reg <= perf_conflict_reg + 32'd1;
            if ((state_reg == GRANT_DM) & if_req)
                perf_if_wait_reg <= perf_if_wait_reg + 32'd1;
        end
    end

    assign perf_conflict = perf_conflict_reg;
    assign perf_if_wait  = perf_if_wait_reg;
`else
    assign perf_conflict = 32'd0;
    assign perf_if_wait  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by randomized traffic. Every cycle is checked
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int SMAX     = 2;
    localparam int OWN_NONE = 0;
    localparam int OWN_IF   = 1;
    localparam int OWN_DM   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        pipe_stall;
    logic [31:0] perf_conflict;
    logic [31:0] perf_if_wait;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pipe_stall(pipe_stall), .perf_conflict(perf_conflict), .perf_if_wait(perf_if_wait)
    );

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model: who owns the memory, the outstanding command,
    // which port is being answered this cycle, and the data each port last saw.
    int          m_owner;
    int          m_starve;
    bit          m_if_ready, m_dm_ready, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata, m_conf, m_wait;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = OWN_NONE; m_starve = 0; m_if_ready = 0; m_dm_ready = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0; m_conf = '0; m_wait = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        bit nif = 0;
        bit ndm = 0;
`ifdef ARB_PERF_CNT_EN
        if (if_req && dm_req && !m_if_ready && !m_dm_ready) m_conf = m_conf + 1;
        if (m_owner == OWN_DM && if_req) m_wait = m_wait + 1;
`endif
        if (m_owner != OWN_NONE) begin
            if (mem_ack) begin
                if (m_owner == OWN_IF) begin
                    m_if_rdata = mem_rdata; nif = 1;
                end else begin
                    if (!m_we) m_dm_rdata = mem_rdata;
                    ndm = 1;
                end
                m_owner = OWN_NONE;
            end
        end else if (!m_if_ready && !m_dm_ready) begin
            if (dm_req && !(if_req && m_starve == SMAX)) begin
                m_owner = OWN_DM; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
                m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
            end else if (if_req) begin
                m_owner = OWN_IF; m_addr = if_addr; m_we = 0; m_starve = 0;
            end
        end
        m_if_ready = nif;
        m_dm_ready = ndm;
    endtask

    task automatic check_outputs();
        chk("mem_req", mem_req, m_owner != OWN_NONE);
        if (m_owner != OWN_NONE) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ready", if_ready, m_if_ready);
        chk("dm_ready", dm_ready, m_dm_ready);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("dm_rdata", dm_rdata, m_dm_rdata);
        chk("perf_conflict", perf_conflict, m_conf);
        chk("perf_if_wait", perf_if_wait, m_wait);
    endtask

    // One clock: check the combinational stall mid-cycle, then step and compare just after the edge.
    task automatic cycle();
        @(negedge clock);
        chk("pipe_stall", pipe_stall, (if_req && !m_if_ready) || (dm_req && !m_dm_ready));
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else model_step();
        check_outputs();
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!mem_req && n < 20) begin
            cycle();
            n++;
        end
        chk({name, "_grant_timeout"}, mem_req, 1);
    endtask

    task automatic ack_after(input int lat, input logic [31:0] d);
        repeat (lat - 1) cycle();
        mem_ack = 1; mem_rdata = d;
        cycle();
        mem_ack = 0; mem_rdata = $urandom;
    endtask

    initial begin
        logic [5:0]  order;
        logic [31:0] wait_before;
        bit          cmd_active;
        int          lat_left;

        model_reset();
        repeat (3) cycle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_ready", dm_ready, 0);
        reset = 0;
        cycle();

        // Fetch only, ack two cycles into the request.
        if_req = 1; if_addr = 32'h40;
        wait_grant("t1");
        chk("t1_addr", mem_addr, 32'h40);
        chk("t1_we", mem_we, 0);
        chk("t1_stall", pipe_stall, 1);
        ack_after(2, 32'h8C220004);
        chk("t1_ready", if_ready, 1);
        chk("t1_rdata", if_rdata, 32'h8C220004);
        if_req = 0;
        cycle();
        chk("t1_ready_once", if_ready, 0);
        chk("t1_rdata_hold", if_rdata, 32'h8C220004);

        // Simultaneous requests: DM first, then fetch.
        if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        wait_grant("t2a");
        chk("t2_dm_first", mem_addr, 32'h100);
        ack_after(1, 32'h11112222);
        chk("t2_dm_ready", dm_ready, 1);
        chk("t2_dm_rdata", dm_rdata, 32'h11112222);
        chk("t2_if_not_ready", if_ready, 0);
        dm_req = 0;
        wait_grant("t2b");
        chk("t2_if_second", mem_addr, 32'h44);
        ack_after(1, 32'h33334444);
        chk("t2_if_rdata", if_rdata, 32'h33334444);

        // Both held continuously with STARVE_MAX=2: DM,DM,IF,DM,DM,IF.
        if_addr = 32'h48; dm_req = 1; dm_addr = 32'h200;
        wait_before = perf_if_wait;
        order = '0;
        for (int g = 0; g < 6; g++) begin
            wait_grant("t3");
            order = {order[4:0], mem_addr == 32'h200};
            ack_after(1, 32'hA0000000 + 32'(g));
        end
        chk("t3_order", order, 6'b110110);
`ifdef ARB_PERF_CNT_EN
        chk("t6_if_wait_delta", perf_if_wait - wait_before, 4);
`else
        chk("t6_if_wait_zero", perf_if_wait, 0);
        chk("t6_conflict_zero", perf_conflict, 0);
`endif
        if_req = 0; dm_req = 0;
        cycle();

        // Store leaves load data alone.
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        wait_grant("t4");
        chk("t4_we", mem_we, 1);
        chk("t4_wdata", mem_wdata, 32'hDEADBEEF);
        ack_after(1, 32'h5555AAAA);
        chk("t4_ready", dm_ready, 1);
        chk("t4_rdata_kept", dm_rdata, 32'hA0000004);
        dm_req = 0; dm_we = 0;
        cycle();

        // Reset during a DM grant abandons it; a late ack is ignored.
        dm_req = 1; dm_addr = 32'h300;
        wait_grant("t5");
        reset = 1; dm_req = 0;
        #1;
        model_reset();
        chk("t5_req_drop", mem_req, 0);
        cycle();
        reset = 0;
        cycle();
        mem_ack = 1; mem_rdata = 32'h77778888;
        cycle();
        mem_ack = 0;
        chk("t5_no_ready", dm_ready, 0);
        chk("t5_idle", mem_req, 0);
        cycle();

        // Randomized traffic with variable memory latency and stray acks.
        cmd_active = 0; lat_left = 0;
        for (int c = 0; c < 4000; c++) begin
            cycle();
            if (if_req) begin
                if (if_ready) begin
                    if ($urandom_range(1) == 1) if_addr = $urandom & 32'hFFFFFFFC;
                    else if_req = 0;
                end else if ($urandom_range(31) == 0) if_req = 0;
            end else if ($urandom_range(2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFFFFFC;
            end
            if (dm_req) begin
                if (dm_ready) begin
                    if ($urandom_range(1) == 1) begin
                        dm_we = $urandom_range(1) == 1; dm_addr = $urandom; dm_wdata = $urandom;
                    end else dm_req = 0;
                end else if ($urandom_range(31) == 0) dm_req = 0;
            end else if ($urandom_range(2) == 0) begin
                dm_req = 1; dm_we = $urandom_range(1) == 1; dm_addr = $urandom; dm_wdata = $urandom;
            end
            mem_ack = 0;
            if (mem_req) begin
                if (!cmd_active) begin
                    cmd_active = 1; lat_left = $urandom_range(2);
                end
                if (lat_left == 0) begin
                    mem_ack = 1; mem_rdata = $urandom; cmd_active = 0;
                end else lat_left--;
            end else begin
                cmd_active = 0;
                if ($urandom_range(7) == 0) begin
                    mem_ack = 1; mem_rdata = $urandom;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
